// File: rtl/cdb_broadcast_arbiter_if.sv
// Producer-side and CDB-side signal bundle of the broadcast arbiter.
// The arbiter takes the slave view; the functional-unit side takes master.
interface cdb_broadcast_arbiter_if #(
  parameter int NUM_SRC   = 3,
  parameter int NUM_LANES = 2,
  parameter int DATA_W    = 32,
  parameter int TAG_W     = 8
);
  logic [NUM_SRC-1:0]          src_valid;
  logic [NUM_SRC*TAG_W-1:0]    src_tag;
  logic [NUM_SRC*DATA_W-1:0]   src_data;
  logic [NUM_SRC-1:0]          src_ready;
  logic [NUM_LANES*TAG_W-1:0]  cdb_tag_serialized;
  logic [NUM_LANES*DATA_W-1:0] cdb_data_serialized;
  logic [NUM_LANES-1:0]        cdb_lane_valid;
  logic                        fifo_overflow_err;

  modport master (
    output src_valid,
    output src_tag,
    output src_data,
    input  src_ready,
    input  cdb_tag_serialized,
    input  cdb_data_serialized,
    input  cdb_lane_valid,
    input  fifo_overflow_err
  );

  modport slave (
    input  src_valid,
    input  src_tag,
    input  src_data,
    output src_ready,
    output cdb_tag_serialized,
    output cdb_data_serialized,
    output cdb_lane_valid,
    output fifo_overflow_err
  );
endinterface

// File: rtl/cdb_broadcast_arbiter.sv
// Buffers functional-unit results in per-source FIFOs and broadcasts
// them round-robin onto NUM_LANES registered CDB lanes.
module cdb_broadcast_arbiter #(
  parameter int NUM_SRC    = 3,
  parameter int NUM_LANES  = 2,
  parameter int DATA_W     = 32,
  parameter int TAG_W      = 8,
  parameter int FIFO_DEPTH = 2
) (
  input logic clk,
  input logic rst_n,
  input logic flush,
  cdb_broadcast_arbiter_if.slave bus
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int PW = AW + 1;
  localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t              mem [NUM_SRC][FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr [NUM_SRC];
  logic [PW-1:0]     rd_ptr [NUM_SRC];
  ent_t              head [NUM_SRC];
  ent_t              in_ent [NUM_SRC];
  ent_t              held [NUM_SRC];
  logic [NUM_SRC-1:0] empty;
  logic [NUM_SRC-1:0] full;
  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] grant;
  logic [NUM_SRC-1:0] changed;
  logic [NUM_SRC-1:0] hold_q;
  logic [SW-1:0]     rr_ptr;
  logic [SW-1:0]     rr_next;
  ent_t              lane_ent [NUM_LANES];
  ent_t              lane_q [NUM_LANES];
  logic              err_q;

  // Power-of-two depth: the low pointer bits address the slot.
  function automatic logic [AW-1:0] slot(input logic [PW-1:0] p);
    return p[AW-1:0] & AW'(FIFO_DEPTH - 1);
  endfunction

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [PW-1:0] occ;
    assign occ       = wr_ptr[i] - rd_ptr[i];
    assign empty[i]  = (occ == '0);
    assign full[i]   = (occ == PW'(FIFO_DEPTH));
    assign in_ent[i].tag  = bus.src_tag[i*TAG_W +: TAG_W];
    assign in_ent[i].data = bus.src_data[i*DATA_W +: DATA_W];
    assign push[i]   = bus.src_valid[i] & ~full[i]
                     & in_ent[i].tag[TAG_W-1] & ~flush;
    assign head[i]   = mem[i][slot(rd_ptr[i])];
    assign changed[i] = (in_ent[i] != held[i]);
  end

  assign bus.src_ready = ~full;
  assign bus.fifo_overflow_err = err_q;

  always_comb begin
    int n;
    int s;
    n        = 0;
    s        = 0;
    grant    = '0;
    rr_next  = rr_ptr;
    lane_ent = '{default: '0};
    for (int k = 0; k < NUM_SRC; k++) begin
      s = int'(rr_ptr) + k;
      if (s >= NUM_SRC) s = s - NUM_SRC;
      if (!empty[s] && n < NUM_LANES) begin
        grant[s]    = 1'b1;
        lane_ent[n] = head[s];
        rr_next     = (s == NUM_SRC - 1) ? '0 : SW'(s + 1);
        n           = n + 1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= '0;
      err_q  <= 1'b0;
      hold_q <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
      for (int l = 0; l < NUM_LANES; l++) lane_q[l] <= '0;
    end else begin
      // A stalled beat must be held stable until it is taken.
      hold_q <= bus.src_valid & full;
      for (int i = 0; i < NUM_SRC; i++) held[i] <= in_ent[i];
      if (|(hold_q & bus.src_valid & changed)) err_q <= 1'b1;
      if (flush) begin
        rr_ptr <= '0;
        for (int i = 0; i < NUM_SRC; i++) begin
          wr_ptr[i] <= '0;
          rd_ptr[i] <= '0;
        end
        for (int l = 0; l < NUM_LANES; l++) lane_q[l] <= '0;
      end else begin
        rr_ptr <= rr_next;
        for (int i = 0; i < NUM_SRC; i++) begin
          if (push[i]) begin
            mem[i][slot(wr_ptr[i])] <= in_ent[i];
            wr_ptr[i] <= wr_ptr[i] + 1'b1;
          end
          if (grant[i]) rd_ptr[i] <= rd_ptr[i] + 1'b1;
        end
        for (int l = 0; l < NUM_LANES; l++) lane_q[l] <= lane_ent[l];
      end
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign bus.cdb_tag_serialized[(NUM_LANES-1-l)*TAG_W +: TAG_W] =
      lane_q[l].tag;
    assign bus.cdb_data_serialized[(NUM_LANES-1-l)*DATA_W +: DATA_W] =
      lane_q[l].data;
    assign bus.cdb_lane_valid[l] = lane_q[l].tag[TAG_W-1];
  end

endmodule

// File: tb/tb_cdb_broadcast_arbiter.sv
// Bench for cdb_broadcast_arbiter: a 2-lane and a 1-lane instance
// driven by random producers and compared to a queue-based model.
module tb_cdb_broadcast_arbiter;
  localparam int NS = 3;
  localparam int DW = 32;
  localparam int TW = 8;
  localparam int FD = 2;
  localparam int SNW = 2*TW + 2*DW + 2 + NS + 1;

  typedef logic [TW+DW-1:0] ent_t;
  typedef logic [SNW-1:0] snap_t;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  always #5 clk = ~clk;

  cdb_broadcast_arbiter_if #(.NUM_SRC(NS), .NUM_LANES(2),
    .DATA_W(DW), .TAG_W(TW)) ifa ();
  cdb_broadcast_arbiter_if #(.NUM_SRC(NS), .NUM_LANES(1),
    .DATA_W(DW), .TAG_W(TW)) ifb ();

  cdb_broadcast_arbiter #(.NUM_SRC(NS), .NUM_LANES(2), .DATA_W(DW),
    .TAG_W(TW), .FIFO_DEPTH(FD)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(ifa));
  cdb_broadcast_arbiter #(.NUM_SRC(NS), .NUM_LANES(1), .DATA_W(DW),
    .TAG_W(TW), .FIFO_DEPTH(FD)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(ifb));

  logic [NS-1:0]    vld [2];
  logic [NS*TW-1:0] tg [2];
  logic [NS*DW-1:0] dt [2];
  logic [2*TW-1:0]  otag [2];
  logic [2*DW-1:0]  odat [2];
  logic [1:0]       olv [2];
  logic [NS-1:0]    ordy [2];
  logic             oerr [2];

  assign ifa.src_valid = vld[0];
  assign ifa.src_tag   = tg[0];
  assign ifa.src_data  = dt[0];
  assign ifb.src_valid = vld[1];
  assign ifb.src_tag   = tg[1];
  assign ifb.src_data  = dt[1];
  assign otag[0] = ifa.cdb_tag_serialized;
  assign otag[1] = {ifb.cdb_tag_serialized, {TW{1'b0}}};
  assign odat[0] = ifa.cdb_data_serialized;
  assign odat[1] = {ifb.cdb_data_serialized, {DW{1'b0}}};
  assign olv[0]  = ifa.cdb_lane_valid;
  assign olv[1]  = {1'b0, ifb.cdb_lane_valid};
  assign ordy[0] = ifa.src_ready;
  assign ordy[1] = ifb.src_ready;
  assign oerr[0] = ifa.fifo_overflow_err;
  assign oerr[1] = ifb.fifo_overflow_err;

  // Reference model: one FIFO queue per source, lane slots padded to 2.
  ent_t            q [2][NS][$];
  int              rr [2];
  logic [2*TW-1:0] etag [2];
  logic [2*DW-1:0] edat [2];
  bit              eerr [2];
  bit              hold [2][NS];
  ent_t            held [2][NS];

  bit   pend [2][NS];
  ent_t pent [2][NS];
  int   seq [2][NS];
  bit   auto_on;
  int   rate;
  int   bad_pct;

  int n_cmp;
  int n_bad;

  function automatic int lanes_of(int d);
    return (d == 0) ? 2 : 1;
  endfunction

  function automatic logic [NS-1:0] exp_rdy(int d);
    logic [NS-1:0] r;
    for (int s = 0; s < NS; s++) r[s] = (q[d][s].size() < FD);
    return r;
  endfunction

  function automatic logic [1:0] exp_lv(int d);
    logic [TW-1:0] t;
    logic [1:0] r;
    for (int l = 0; l < 2; l++) begin
      t = etag[d][(1-l)*TW +: TW];
      r[l] = t[TW-1];
    end
    return r;
  endfunction

  function automatic snap_t mdl(int d);
    return {etag[d], edat[d], exp_lv(d), exp_rdy(d), eerr[d]};
  endfunction

  function automatic snap_t obs(int d);
    return {otag[d], odat[d], olv[d], ordy[d], oerr[d]};
  endfunction

  task automatic drive();
    for (int d = 0; d < 2; d++)
      for (int s = 0; s < NS; s++) begin
        vld[d][s] = pend[d][s];
        tg[d][s*TW +: TW] = pent[d][s][TW+DW-1 -: TW];
        dt[d][s*DW +: DW] = pent[d][s][DW-1:0];
      end
  endtask

  task automatic new_beat(int d, int s);
    logic [TW-1:0] t;
    if ($urandom_range(99) < bad_pct) begin
      t = {1'b0, 7'($urandom)};
    end else begin
      seq[d][s] = seq[d][s] + 1;
      t = {1'b1, 2'(s), 5'(seq[d][s])};
    end
    pent[d][s] = {t, 32'($urandom)};
    pend[d][s] = 1'b1;
  endtask

  task automatic offer(int d, int s, logic [TW-1:0] t, logic [DW-1:0] v);
    pent[d][s] = {t, v};
    pend[d][s] = 1'b1;
  endtask

  // Advance one clock: model the coming edge, then refresh producers.
  task automatic tick();
    bit   acc [2][NS];
    ent_t e;
    int   n;
    int   last;
    int   s;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        for (int i = 0; i < NS; i++) begin
          q[d][i].delete();
          acc[d][i] = 1'b0;
          hold[d][i] = 1'b0;
        end
        rr[d] = 0;
        etag[d] = '0;
        edat[d] = '0;
        eerr[d] = 1'b0;
      end else begin
        for (int i = 0; i < NS; i++) begin
          e = {tg[d][i*TW +: TW], dt[d][i*DW +: DW]};
          acc[d][i] = vld[d][i] && (q[d][i].size() < FD);
          if (hold[d][i] && vld[d][i] && e !== held[d][i]) eerr[d] = 1'b1;
          hold[d][i] = vld[d][i] && !acc[d][i];
          held[d][i] = e;
        end
        if (flush) begin
          for (int i = 0; i < NS; i++) q[d][i].delete();
          rr[d] = 0;
          etag[d] = '0;
          edat[d] = '0;
        end else begin
          etag[d] = '0;
          edat[d] = '0;
          n = 0;
          last = -1;
          for (int k = 0; k < NS; k++) begin
            s = (rr[d] + k) % NS;
            if (q[d][s].size() > 0 && n < lanes_of(d)) begin
              e = q[d][s].pop_front();
              etag[d][(1-n)*TW +: TW] = e[TW+DW-1 -: TW];
              edat[d][(1-n)*DW +: DW] = e[DW-1:0];
              n = n + 1;
              last = s;
            end
          end
          if (last >= 0) rr[d] = (last + 1) % NS;
          for (int i = 0; i < NS; i++)
            if (acc[d][i] && tg[d][i*TW + TW - 1])
              q[d][i].push_back({tg[d][i*TW +: TW], dt[d][i*DW +: DW]});
        end
      end
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < NS; i++) begin
        if (acc[d][i]) pend[d][i] = 1'b0;
        if (auto_on && !pend[d][i] && $urandom_range(99) < rate)
          new_beat(d, i);
      end
    drive();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (obs(d) !== mdl(d)) begin
          n_bad++;
          $display("FAIL reset_idle d%0d: got %h want %h", d, obs(d), mdl(d));
        end
        n_cmp++;
        if (olv[d] !== 2'b00 || ordy[d] !== 3'b111 || otag[d] !== '0) begin
          n_bad++;
          $display("FAIL reset_idle_const d%0d: lv=%b rdy=%b tag=%h want 00 111 0",
                   d, olv[d], ordy[d], otag[d]);
        end
      end
    end
  endtask

  task automatic test_three_push();
    logic [2*TW-1:0] want [2][3];
    want[0][0] = 16'h0000; want[0][1] = 16'h8182; want[0][2] = 16'h8300;
    want[1][0] = 16'h0000; want[1][1] = 16'h8100; want[1][2] = 16'h8200;
    for (int d = 0; d < 2; d++) begin
      offer(d, 0, 8'h81, 32'h11);
      offer(d, 1, 8'h82, 32'h22);
      offer(d, 2, 8'h83, 32'h33);
    end
    drive();
    for (int c = 0; c < 4; c++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (obs(d) !== mdl(d)) begin
          n_bad++;
          $display("FAIL three_push d%0d c%0d: got %h want %h",
                   d, c, obs(d), mdl(d));
        end
        if (c < 3) begin
          n_cmp++;
          if (otag[d] !== want[d][c]) begin
            n_bad++;
            $display("FAIL three_push_tags d%0d c%0d: got %h want %h",
                     d, c, otag[d], want[d][c]);
          end
        end
      end
    end
    n_cmp++;
    if (odat[1] !== {32'h33, 32'h0}) begin
      n_bad++;
      $display("FAIL three_push_data: got %h want %h", odat[1], {32'h33, 32'h0});
    end
  endtask

  task automatic test_back_to_back();
    logic [TW-1:0] seen [$];
    logic [TW-1:0] t;
    logic [DW-1:0] v;
    for (int c = 0; c < 6; c++) begin
      if (c < 3) begin
        t = 8'hA1 + 8'(c);
        v = $urandom;
        offer(0, 1, t, v);
        offer(1, 1, t, v);
        drive();
      end
      tick();
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (obs(d) !== mdl(d)) begin
          n_bad++;
          $display("FAIL back_to_back d%0d: got %h want %h", d, obs(d), mdl(d));
        end
      end
      n_cmp++;
      if (ordy[1][1] !== 1'b1) begin
        n_bad++;
        $display("FAIL b2b_ready: got %b want 1", ordy[1][1]);
      end
      if (olv[1][0]) seen.push_back(otag[1][TW +: TW]);
    end
    n_cmp++;
    if (seen.size() != 3 || seen[0] !== 8'hA1 || seen[1] !== 8'hA2
        || seen[2] !== 8'hA3) begin
      n_bad++;
      $display("FAIL b2b_order: got %0d beats %p want A1 A2 A3", seen.size(), seen);
    end
  endtask

  task automatic test_saturate();
    int last_seen [NS];
    int src;
    bit saw_full;
    saw_full = 1'b0;
    for (int s = 0; s < NS; s++) last_seen[s] = -1;
    auto_on = 1'b1;
    rate = 100;
    bad_pct = 0;
    tick();
    for (int c = 0; c < 30; c++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (obs(d) !== mdl(d)) begin
          n_bad++;
          $display("FAIL saturate d%0d c%0d: got %h want %h",
                   d, c, obs(d), mdl(d));
        end
      end
      if (ordy[1] !== 3'b111) saw_full = 1'b1;
      if (olv[1][0]) begin
        src = int'(otag[1][TW+5 +: 2]);
        if (c >= 5 && last_seen[src] >= 0) begin
          n_cmp++;
          if (c - last_seen[src] > 3) begin
            n_bad++;
            $display("FAIL starve src%0d: gap %0d want <=3",
                     src, c - last_seen[src]);
          end
        end
        last_seen[src] = c;
      end
    end
    n_cmp++;
    if (!saw_full) begin
      n_bad++;
      $display("FAIL saturate_full: ready never dropped, want some 0");
    end
    auto_on = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (obs(d) !== mdl(d)) begin
          n_bad++;
          $display("FAIL drain d%0d: got %h want %h", d, obs(d), mdl(d));
        end
      end
    end
  endtask

  task automatic test_invalid_tag();
    for (int d = 0; d < 2; d++) offer(d, 0, 8'h05, 32'hDEAD_BEEF);
    drive();
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (ordy[d][0] !== 1'b1) begin
        n_bad++;
        $display("FAIL invalid_ready d%0d: got %b want 1", d, ordy[d][0]);
      end
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (obs(d) !== mdl(d) || otag[d] !== '0 || ordy[d] !== 3'b111) begin
          n_bad++;
          $display("FAIL invalid_tag d%0d: got %h want %h", d, obs(d), mdl(d));
        end
      end
    end
  endtask

  task automatic test_flush();
    logic [TW-1:0] flushed [2][$];
    logic [NS-1:0] r;
    logic [TW-1:0] t;
    auto_on = 1'b1;
    rate = 100;
    bad_pct = 0;
    for (int c = 0; c < 8; c++) tick();
    for (int d = 0; d < 2; d++) begin
      r = exp_rdy(d);
      for (int s = 0; s < NS; s++)
        if (pend[d][s] && r[s]) flushed[d].push_back(pent[d][s][TW+DW-1 -: TW]);
    end
    auto_on = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (obs(d) !== mdl(d) || otag[d] !== '0 || odat[d] !== '0
          || ordy[d] !== 3'b111) begin
        n_bad++;
        $display("FAIL flush_clear d%0d: got %h want %h", d, obs(d), mdl(d));
      end
    end
    for (int c = 0; c < 10; c++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (obs(d) !== mdl(d)) begin
          n_bad++;
          $display("FAIL post_flush d%0d: got %h want %h", d, obs(d), mdl(d));
        end
        for (int l = 0; l < lanes_of(d); l++) begin
          t = otag[d][(1-l)*TW +: TW];
          if (olv[d][l]) begin
            n_cmp++;
            foreach (flushed[d][i])
              if (flushed[d][i] === t) begin
                n_bad++;
                $display("FAIL flushed_beat d%0d: tag %h seen, want never", d, t);
              end
          end
        end
      end
    end
  endtask

  task automatic test_random();
    auto_on = 1'b1;
    rate = 50;
    bad_pct = 15;
    for (int c = 0; c < 300; c++) begin
      flush = ($urandom_range(99) < 3);
      tick();
      flush = 1'b0;
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (obs(d) !== mdl(d)) begin
          n_bad++;
          $display("FAIL random d%0d c%0d: got %h want %h",
                   d, c, obs(d), mdl(d));
        end
      end
    end
    auto_on = 1'b0;
    for (int c = 0; c < 8; c++) tick();
  endtask

  task automatic test_overflow();
    logic [NS-1:0] r;
    int pick;
    auto_on = 1'b1;
    rate = 100;
    bad_pct = 0;
    for (int c = 0; c < 6; c++) tick();
    auto_on = 1'b0;
    r = exp_rdy(1);
    pick = -1;
    for (int s = 0; s < NS; s++)
      if (pick < 0 && pend[1][s] && hold[1][s] && !r[s]) pick = s;
    n_cmp++;
    if (pick < 0) begin
      n_bad++;
      $display("FAIL overflow_setup: no stalled source, want one");
    end else begin
      pent[1][pick][0] = ~pent[1][pick][0];
      drive();
    end
    tick();
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (obs(d) !== mdl(d)) begin
        n_bad++;
        $display("FAIL overflow d%0d: got %h want %h", d, obs(d), mdl(d));
      end
    end
    n_cmp++;
    if (oerr[1] !== 1'b1 || oerr[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL overflow_flag: got %b%b want 01", oerr[0], oerr[1]);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    n_cmp++;
    if (oerr[1] !== 1'b1) begin
      n_bad++;
      $display("FAIL overflow_sticky: got %b want 1", oerr[1]);
    end
  endtask

  task automatic test_reset_midburst();
    auto_on = 1'b1;
    rate = 70;
    bad_pct = 10;
    for (int c = 0; c < 5; c++) tick();
    auto_on = 1'b0;
    for (int d = 0; d < 2; d++)
      for (int s = 0; s < NS; s++) pend[d][s] = 1'b0;
    drive();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (obs(d) !== mdl(d) || otag[d] !== '0 || ordy[d] !== 3'b111
            || oerr[d] !== 1'b0) begin
          n_bad++;
          $display("FAIL reset_midburst d%0d: got %h want %h",
                   d, obs(d), mdl(d));
        end
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    auto_on = 1'b0;
    rate = 0;
    bad_pct = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    for (int d = 0; d < 2; d++) begin
      rr[d] = 0;
      etag[d] = '0;
      edat[d] = '0;
      eerr[d] = 1'b0;
      for (int s = 0; s < NS; s++) begin
        pend[d][s] = 1'b0;
        pent[d][s] = '0;
        seq[d][s] = 0;
        hold[d][s] = 1'b0;
        held[d][s] = '0;
      end
    end
    drive();
    @(negedge clk);
    test_reset();
    test_three_push();
    test_back_to_back();
    test_saturate();
    test_invalid_tag();
    test_flush();
    test_random();
    test_overflow();
    test_reset_midburst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cdb_broadcast_arbiter.md
Name: cdb_broadcast_arbiter

Overview:
- Parametrised successor to the fixed three-way CDB router. Collects completed results (tag + data) from NUM_SRC functional units (adder, multiplier, memory, and others).
- Buffers results in per-source FIFOs and arbitrates them round-robin onto NUM_LANES CDB lanes. Lane outputs are registered.
- Lane outputs use the serialized format consumed by the reservation stations and the register file.
- Unlike the current router, it exerts backpressure on the units, drops invalid tags and supports flush.

Parameters:
- NUM_SRC, 3, number of producing functional units (>=1)
- NUM_LANES, 2, number of CDB broadcast lanes per cycle (1..NUM_SRC)
- DATA_W, 32, result data width
- TAG_W, 8, tag width; MSB is the tag-valid bit
- FIFO_DEPTH, 2, entries per source FIFO (power of two, >=1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- flush  in  1  synchronous clear of all buffered and in-flight results
- src_valid  in  NUM_SRC  per-source result valid
- src_tag  in  NUM_SRC*TAG_W  per-source tag; source i at bits [i*TAG_W +: TAG_W]
- src_data  in  NUM_SRC*DATA_W  per-source data; same packing as src_tag
- src_ready  out  NUM_SRC  per-source FIFO can accept
- cdb_tag_serialized  out  NUM_LANES*TAG_W  lane tags; lane 0 in MS slice; tag 0 means lane idle
- cdb_data_serialized  out  NUM_LANES*DATA_W  lane data; same ordering; 0 when lane idle
- cdb_lane_valid  out  NUM_LANES  per-lane broadcast valid, equals the lane tag MSB
- fifo_overflow_err  out  1  sticky error flag

Behaviour:
- Reset (rst_n=0 at an edge): all FIFOs empty, rr_ptr=0, all cdb_* outputs 0, fifo_overflow_err=0, src_ready all 1 from the following cycle.
- src_ready[i] = !full[i], computed from current occupancy only. There is no pass-through on a simultaneous pop, so a full FIFO shows ready=0 even when it is popped that cycle.
- Push: at an edge with src_valid[i] && src_ready[i] && src_tag[i][TAG_W-1]=1, the entry is written to FIFO i.
- If the tag MSB is 0, the beat is consumed (handshake completes) but discarded.
- If src_valid[i]=1 while src_ready[i]=0, the beat is not taken and the source must hold it. If src_tag/src_data change while held, fifo_overflow_err sets (sticky until reset).
- Arbitration runs combinationally each cycle on the FIFO heads:
  - Scan sources in order rr_ptr, rr_ptr+1, ... modulo NUM_SRC.
  - The first non-empty source goes to lane 0, the next to lane 1, and so on, up to NUM_LANES grants.
  - Granted FIFOs pop at the edge.
- At the same edge, lane registers load the granted tag/data. Ungranted lanes load tag 0 and data 0.
- rr_ptr update: if at least one grant, rr_ptr = (index of the last granted source + 1) mod NUM_SRC; with no grant, rr_ptr holds.
- Latency: a beat accepted at edge k reaches the CDB outputs at edge k+1 at the earliest (visible through the cycle after k+1). The lane register holds for exactly one cycle, so a broadcast is a one-cycle pulse.
- Throughput: up to NUM_LANES broadcasts per cycle. With FIFO_DEPTH=2, a single source sustains one result per cycle without stall.
- Ordering: results from the same source are broadcast in acceptance order. There is no ordering guarantee across sources.
- Duplicate-tag detection is out of scope; tag uniqueness is guaranteed by the issue stage.
- flush=1 at an edge: all FIFOs empty, lane registers clear to 0, rr_ptr reset to 0, pushes that cycle are discarded (src_ready reads 1 for non-full sources but the data is dropped). fifo_overflow_err is unaffected.
- rst_n has priority over flush.
- Wrap-around: FIFO read/write pointers carry one extra bit for the full/empty distinction. rr_ptr wraps from NUM_SRC-1 to 0.
- Reset asserted mid-burst: all pending results are lost; outputs are 0 from the following cycle.

Test Plan:
- Reset, then idle with src_valid=0 -> all cdb_* outputs 0, src_ready=3'b111, rr_ptr=0, no lane valid for 10 cycles.
- Push 3 sources in one cycle (tags 0x81, 0x82, 0x83, data 0x11, 0x22, 0x33) with NUM_LANES=2 -> next cycle lanes {0x81, 0x82}; following cycle lane 0=0x83, lane 1=0x00; rr_ptr then sequences 0 -> 2 -> 0.
- Source 1 pushes 3 back-to-back beats while the other sources are idle, NUM_LANES=1 -> tags broadcast in order on consecutive cycles, src_ready[1] never deasserts.
- Hold all sources valid continuously for 30 cycles (NUM_LANES=1) -> grants rotate 0,1,2,0,... with no source starved more than 2 cycles; a full FIFO shows src_ready=0.
- Push with tag 0x05 (MSB=0) -> handshake completes, no broadcast, FIFO occupancy unchanged.
- Fill FIFOs, then assert flush for one cycle -> next cycle all lanes 0 and all FIFOs empty; a beat pushed in the flush cycle never appears.
